// File: rtl/priority_scan_enc_if.sv
// Request/index handshake bundle for priority_scan_enc.
// master drives requests and accepts indices; slave is the encoder.
interface priority_scan_enc_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_req;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic [CNT_W-1:0] hit_cnt;
  logic             zero_req;

  modport master (
    output in_valid,
    output in_req,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  hit_cnt,
    input  zero_req
  );

  modport slave (
    input  in_valid,
    input  in_req,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output hit_cnt,
    output zero_req
  );
endinterface

// File: rtl/priority_scan_enc.sv
// Serialises a captured request vector into set-bit indices, bit 0 first.
// Optional PSE_FLUSH_EN adds a flush input that aborts a running scan.
module priority_scan_enc #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
`ifdef PSE_FLUSH_EN
  input logic flush,
`endif
  priority_scan_enc_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] hit_d;
  logic             zero_q;
  logic             zero_d;
  logic [IDX_W-1:0] low_idx;
  logic [CNT_W-1:0] req_cnt;
  logic [WIDTH-1:0] pend_drop;
  logic             one_left;

  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      req_cnt = req_cnt + CNT_W'(bus.in_req[i]);
    end
  end

  // x & (x-1) strips the lowest set bit
  assign pend_drop = pending_q & (pending_q - WIDTH'(1));
  assign one_left  = (pending_q != '0) && (pend_drop == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    hit_d     = hit_q;
    zero_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pending_d = bus.in_req;
          hit_d     = req_cnt;
          if (bus.in_req != '0) state_d = SCAN;
          else                  zero_d  = 1'b1;
        end
      end
      SCAN: begin
`ifdef PSE_FLUSH_EN
        if (flush) begin
          pending_d = '0;
          state_d   = IDLE;
        end else
`endif
        if (bus.out_ready) begin
          pending_d = pend_drop;
          if (one_left) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      hit_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hit_q     <= hit_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == SCAN);
  assign bus.out_idx   = low_idx;
  assign bus.out_last  = one_left;
  assign bus.hit_cnt   = hit_q;
  assign bus.zero_req  = zero_q;
endmodule

// File: tb/tb_priority_scan_enc.sv
// Randomised and directed checks of priority_scan_enc against a
// queue-of-indices model of the scan.
module tb_priority_scan_enc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fl  = 1'b0;

  int tests = 0;
  int fails = 0;

  int q[$];
  bit busy;
  int exp_hit;
  bit exp_zero;

  priority_scan_enc_if #(.WIDTH(8)) bus ();

  priority_scan_enc #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PSE_FLUSH_EN
    .flush(fl),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy     = 0;
    exp_hit  = 0;
    exp_zero = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(busy));
    chk("in_ready", 32'(bus.in_ready), 32'(!busy));
    chk("hit_cnt", 32'(bus.hit_cnt), 32'(exp_hit));
    chk("zero_req", 32'(bus.zero_req), 32'(exp_zero));
    if (busy) begin
      chk("out_idx", 32'(bus.out_idx), 32'(q[0]));
      chk("out_last", 32'(bus.out_last), 32'(q.size() == 1));
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] r,
                            input bit rdy, input bit f);
    exp_zero = 0;
    if (!busy) begin
      if (v) begin
        q.delete();
        for (int i = 0; i < 8; i++) if (r[i]) q.push_back(i);
        exp_hit  = q.size();
        busy     = (q.size() != 0);
        exp_zero = (q.size() == 0);
      end
    end else if (f) begin
      q.delete();
      busy = 0;
    end else if (rdy) begin
      void'(q.pop_front());
      if (q.size() == 0) busy = 0;
    end
  endtask

  // Check, drive next inputs, advance the model and the clock.
  task automatic cycle(input bit v, input logic [7:0] r,
                       input bit rdy, input bit f = 1'b0);
    check_outputs();
    bus.in_valid  = v;
    bus.in_req    = r;
    bus.out_ready = rdy;
    fl            = f;
    model_step(v, r, rdy, f);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] r;
    bus.in_valid  = 1'b0;
    bus.in_req    = '0;
    bus.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_hit", 32'(bus.hit_cnt), 32'd0);
    chk("rst_zero", 32'(bus.zero_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: three hits
    cycle(1'b1, 8'hA4, 1'b1);
    chk("t1_hit", 32'(bus.hit_cnt), 32'd3);
    chk("t1_idx0", 32'(bus.out_idx), 32'd2);
    drain(4);

    // 2: all-zero vector
    cycle(1'b1, 8'h00, 1'b1);
    chk("t2_zero", 32'(bus.zero_req), 32'd1);
    drain(2);

    // 3: all ones with stalls
    cycle(1'b1, 8'hFF, 1'b0);
    chk("t3_hit", 32'(bus.hit_cnt), 32'd8);
    for (int k = 0; k < 18; k++) cycle(1'b0, 8'h00, k[0]);
    drain(2);

    // 4: async reset mid-scan
    cycle(1'b1, 8'hF0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t4_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_idx", 32'(bus.out_idx), 32'd0);
    chk("t4_hit", 32'(bus.hit_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cycle(1'b1, 8'h01, 1'b1);
    chk("t4_last", 32'(bus.out_last), 32'd1);
    drain(2);

`ifdef PSE_FLUSH_EN
    // 5: flush after first beat
    cycle(1'b1, 8'h0F, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_ready", 32'(bus.in_ready), 32'd1);
    drain(2);
`endif

    // 6: in_valid held through a scan
    cycle(1'b1, 8'h03, 1'b1);
    cycle(1'b1, 8'h81, 1'b1);
    cycle(1'b1, 8'h81, 1'b1);
    chk("t6_ready", 32'(bus.in_ready), 32'd1);
    cycle(1'b1, 8'h81, 1'b1);
    chk("t6_idx", 32'(bus.out_idx), 32'd0);
    drain(4);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       r = 8'h00;
        1:       r = 8'hFF;
        2:       r = 8'(1 << $urandom_range(0, 7));
        default: r = 8'($urandom);
      endcase
`ifdef PSE_FLUSH_EN
      cycle(1'($urandom_range(0, 1)), r, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
`else
      cycle(1'($urandom_range(0, 1)), r, ($urandom_range(0, 3) != 0));
`endif
    end
    drain(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
